// File: rtl/bypass_front_split_pkg.sv
// Shared types for the ingress bypass splitter: metadata layout, stream widths
// and the steering FSM encoding.
package bypass_front_split_pkg;

  localparam int PKT_W   = 512;
  localparam int EMPTY_W = 6;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [7:0]  nf_id;
    logic [2:0]  prio;
    logic [3:0]  rsvd;
    logic        bypass;
  } metadata_t;

  // Position of metadata_t.bypass in the packed vector.
  localparam int META_BYPASS_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    WAIT_META
  } state_t;

endpackage

// File: rtl/bypass_front_split.sv
// Steers each packet (metadata plus all beats) to the NF path or the bypass
// path, deciding once per packet from the metadata bypass bit and NF back-pressure.
module bypass_front_split
  import bypass_front_split_pkg::*;
#(
  parameter int unsigned META_W      = $bits(metadata_t),
  parameter int unsigned BYPASS_BIT  = META_BYPASS_BIT,
  parameter bit          FORCE_ON_AF = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PKT_W-1:0]   in_pkt_data,
  input  logic               in_pkt_sop,
  input  logic               in_pkt_eop,
  input  logic [EMPTY_W-1:0] in_pkt_empty,
  input  logic               in_pkt_valid,
  output logic               in_pkt_ready,
  input  logic [META_W-1:0]  in_meta_data,
  input  logic               in_meta_valid,
  output logic               in_meta_ready,
  output logic [PKT_W-1:0]   out_pkt_data,
  output logic               out_pkt_sop,
  output logic               out_pkt_eop,
  output logic [EMPTY_W-1:0] out_pkt_empty,
  output logic               out_pkt_valid,
  input  logic               out_pkt_ready,
  input  logic               out_pkt_almost_full,
  output logic [META_W-1:0]  out_meta_data,
  output logic               out_meta_valid,
  input  logic               out_meta_ready,
  input  logic               out_meta_almost_full,
  output logic [PKT_W-1:0]   bypass_pkt_data,
  output logic               bypass_pkt_sop,
  output logic               bypass_pkt_eop,
  output logic [EMPTY_W-1:0] bypass_pkt_empty,
  output logic               bypass_pkt_valid,
  input  logic               bypass_pkt_ready,
  output logic [META_W-1:0]  bypass_meta_data,
  output logic               bypass_meta_valid,
  input  logic               bypass_meta_ready,
  output logic [31:0]        stat_nf_pkts,
  output logic [31:0]        stat_bypass_pkts,
  output logic [31:0]        stat_orphan_beats
);

  state_t            state, state_nxt;
  logic [META_W-1:0] meta_reg;
  logic              meta_pend;
  logic              sel;
  logic [31:0]       nf_cnt, bypass_cnt, orphan_cnt;

  logic sel_pkt_ready, sel_meta_ready, meta_fire, force_bypass;
  logic capture, eop_fire, orphan_drop;

  assign force_bypass   = FORCE_ON_AF && (out_pkt_almost_full || out_meta_almost_full);
  assign sel_pkt_ready  = sel ? bypass_pkt_ready  : out_pkt_ready;
  assign sel_meta_ready = sel ? bypass_meta_ready : out_meta_ready;
  assign meta_fire      = !rst && meta_pend && sel_meta_ready;

  assign out_pkt_data     = in_pkt_data;
  assign out_pkt_sop      = in_pkt_sop;
  assign out_pkt_eop      = in_pkt_eop;
  assign out_pkt_empty    = in_pkt_empty;
  assign bypass_pkt_data  = in_pkt_data;
  assign bypass_pkt_sop   = in_pkt_sop;
  assign bypass_pkt_eop   = in_pkt_eop;
  assign bypass_pkt_empty = in_pkt_empty;

  assign out_meta_data     = meta_reg;
  assign bypass_meta_data  = meta_reg;
  assign out_meta_valid    = !rst && meta_pend && !sel;
  assign bypass_meta_valid = !rst && meta_pend && sel;

  assign stat_nf_pkts      = nf_cnt;
  assign stat_bypass_pkts  = bypass_cnt;
  assign stat_orphan_beats = orphan_cnt;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt        = state;
    in_meta_ready    = 1'b0;
    in_pkt_ready     = 1'b0;
    out_pkt_valid    = 1'b0;
    bypass_pkt_valid = 1'b0;
    capture          = 1'b0;
    eop_fire         = 1'b0;
    orphan_drop      = 1'b0;
    if (rst) begin
      // The beat presented during reset is consumed and discarded.
      in_pkt_ready = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          in_meta_ready = 1'b1;
          orphan_drop   = in_pkt_valid && !in_pkt_sop;
          in_pkt_ready  = orphan_drop;
          if (in_meta_valid) begin
            capture   = 1'b1;
            state_nxt = PKT;
          end
        end
        PKT: begin
          in_pkt_ready     = sel_pkt_ready;
          out_pkt_valid    = in_pkt_valid && !sel;
          bypass_pkt_valid = in_pkt_valid && sel;
          if (in_pkt_valid && sel_pkt_ready && in_pkt_eop) begin
            eop_fire  = 1'b1;
            state_nxt = (meta_pend && !meta_fire) ? WAIT_META : IDLE;
          end
        end
        WAIT_META: begin
          if (!meta_pend || meta_fire) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      meta_pend  <= 1'b0;
      sel        <= 1'b0;
      nf_cnt     <= '0;
      bypass_cnt <= '0;
      orphan_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        sel       <= in_meta_data[BYPASS_BIT] | force_bypass;
        meta_pend <= 1'b1;
      end else if (meta_fire) begin
        meta_pend <= 1'b0;
      end
      if (eop_fire && !sel) nf_cnt     <= nf_cnt + 32'd1;
      if (eop_fire && sel)  bypass_cnt <= bypass_cnt + 32'd1;
      if (orphan_drop)      orphan_cnt <= orphan_cnt + 32'd1;
    end
  end

  // NOTE: meta_reg is pure datapath qualified by meta_pend, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) meta_reg <= in_meta_data;
  end

endmodule

// File: tb/tb_bypass_front_split.sv
// Self-checking bench for bypass_front_split: directed scenarios plus random
// traffic scored against a per-packet steering model.
module tb_bypass_front_split;
  import bypass_front_split_pkg::*;

  localparam int META_W = $bits(metadata_t);
  localparam int BUDGET = 200;
  localparam bit FORCE_DUT = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, nf_hold, nf_rst;
  logic [PKT_W-1:0] in_pkt_data;
  logic in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_ready;
  logic [EMPTY_W-1:0] in_pkt_empty;
  logic [META_W-1:0] in_meta_data;
  logic in_meta_valid, in_meta_ready;
  logic [PKT_W-1:0] out_pkt_data, bypass_pkt_data;
  logic out_pkt_sop, out_pkt_eop, out_pkt_valid, out_pkt_ready, out_pkt_almost_full;
  logic bypass_pkt_sop, bypass_pkt_eop, bypass_pkt_valid, bypass_pkt_ready;
  logic [EMPTY_W-1:0] out_pkt_empty, bypass_pkt_empty;
  logic [META_W-1:0] out_meta_data, bypass_meta_data;
  logic out_meta_valid, out_meta_ready, out_meta_almost_full;
  logic bypass_meta_valid, bypass_meta_ready;
  logic [31:0] stat_nf_pkts, stat_bypass_pkts, stat_orphan_beats;

  // Second instance with forcing disabled, only live during the almost-full scenario.
  logic nf2_in_pkt_ready, nf2_in_meta_ready;
  logic [PKT_W-1:0] nf2_out_pkt_data, nf2_bypass_pkt_data;
  logic nf2_out_pkt_sop, nf2_out_pkt_eop, nf2_out_pkt_valid;
  logic nf2_bypass_pkt_sop, nf2_bypass_pkt_eop, nf2_bypass_pkt_valid;
  logic [EMPTY_W-1:0] nf2_out_pkt_empty, nf2_bypass_pkt_empty;
  logic [META_W-1:0] nf2_out_meta_data, nf2_bypass_meta_data;
  logic nf2_out_meta_valid, nf2_bypass_meta_valid;
  logic [31:0] nf2_stat_nf, nf2_stat_bypass, nf2_stat_orphan;
  assign nf_rst = rst | nf_hold;

  bypass_front_split #(.FORCE_ON_AF(FORCE_DUT)) dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_pkt_almost_full(out_pkt_almost_full),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .out_meta_almost_full(out_meta_almost_full),
    .bypass_pkt_data(bypass_pkt_data), .bypass_pkt_sop(bypass_pkt_sop), .bypass_pkt_eop(bypass_pkt_eop),
    .bypass_pkt_empty(bypass_pkt_empty), .bypass_pkt_valid(bypass_pkt_valid),
    .bypass_pkt_ready(bypass_pkt_ready),
    .bypass_meta_data(bypass_meta_data), .bypass_meta_valid(bypass_meta_valid),
    .bypass_meta_ready(bypass_meta_ready),
    .stat_nf_pkts(stat_nf_pkts), .stat_bypass_pkts(stat_bypass_pkts),
    .stat_orphan_beats(stat_orphan_beats)
  );

  bypass_front_split #(.FORCE_ON_AF(1'b0)) u_noforce (
    .clk(clk), .rst(nf_rst),
    .in_pkt_data(in_pkt_data), .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(nf2_in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(nf2_in_meta_ready),
    .out_pkt_data(nf2_out_pkt_data), .out_pkt_sop(nf2_out_pkt_sop), .out_pkt_eop(nf2_out_pkt_eop),
    .out_pkt_empty(nf2_out_pkt_empty), .out_pkt_valid(nf2_out_pkt_valid), .out_pkt_ready(1'b1),
    .out_pkt_almost_full(out_pkt_almost_full),
    .out_meta_data(nf2_out_meta_data), .out_meta_valid(nf2_out_meta_valid), .out_meta_ready(1'b1),
    .out_meta_almost_full(out_meta_almost_full),
    .bypass_pkt_data(nf2_bypass_pkt_data), .bypass_pkt_sop(nf2_bypass_pkt_sop),
    .bypass_pkt_eop(nf2_bypass_pkt_eop), .bypass_pkt_empty(nf2_bypass_pkt_empty),
    .bypass_pkt_valid(nf2_bypass_pkt_valid), .bypass_pkt_ready(1'b1),
    .bypass_meta_data(nf2_bypass_meta_data), .bypass_meta_valid(nf2_bypass_meta_valid),
    .bypass_meta_ready(1'b1),
    .stat_nf_pkts(nf2_stat_nf), .stat_bypass_pkts(nf2_stat_bypass),
    .stat_orphan_beats(nf2_stat_orphan)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: one packet decided at a time, pending metadata per path.
  logic [META_W-1:0] meta_q_nf[$];
  logic [META_W-1:0] meta_q_by[$];
  bit          m_active, m_dest, m_busy, m_rdy;
  logic [31:0] m_cnt_nf, m_cnt_by, m_orphan;
  metadata_t   m_md;
  bit          started = 1'b0;
  int          nf_beats, byp_beats, byp_valid_cycles, nf2_beats;
  logic [EMPTY_W-1:0] last_byp_empty;

  always @(negedge clk) begin
    if (started) begin
      if (rst) begin
        check("rst_valids", {out_pkt_valid, out_meta_valid, bypass_pkt_valid, bypass_meta_valid}, 4'b0);
        check("rst_meta_ready", in_meta_ready, 1'b0);
        m_active = 1'b0;
        meta_q_nf.delete();
        meta_q_by.delete();
        m_cnt_nf = '0;
        m_cnt_by = '0;
        m_orphan = '0;
      end else begin
        m_busy = m_active || (meta_q_nf.size() != 0) || (meta_q_by.size() != 0);
        check("meta_ready", in_meta_ready, !m_busy);
        check("nf_meta_valid", out_meta_valid, meta_q_nf.size() != 0);
        check("byp_meta_valid", bypass_meta_valid, meta_q_by.size() != 0);
        if (out_meta_valid && meta_q_nf.size() != 0) check("nf_meta_data", out_meta_data, meta_q_nf[0]);
        if (bypass_meta_valid && meta_q_by.size() != 0) check("byp_meta_data", bypass_meta_data, meta_q_by[0]);
        check("nf_pkt_valid", out_pkt_valid, m_active && !m_dest && in_pkt_valid);
        check("byp_pkt_valid", bypass_pkt_valid, m_active && m_dest && in_pkt_valid);
        if (in_pkt_valid) begin
          if (m_active) m_rdy = m_dest ? bypass_pkt_ready : out_pkt_ready;
          else          m_rdy = !m_busy && !in_pkt_sop;
          check("pkt_ready", in_pkt_ready, m_rdy);
          if (m_active && m_dest) begin
            check("byp_data", bypass_pkt_data, in_pkt_data);
            check("byp_ctl", {bypass_pkt_sop, bypass_pkt_eop, bypass_pkt_empty},
                  {in_pkt_sop, in_pkt_eop, in_pkt_empty});
          end else if (m_active) begin
            check("nf_data", out_pkt_data, in_pkt_data);
            check("nf_ctl", {out_pkt_sop, out_pkt_eop, out_pkt_empty},
                  {in_pkt_sop, in_pkt_eop, in_pkt_empty});
          end
        end
        check("stat_nf", stat_nf_pkts, m_cnt_nf);
        check("stat_bypass", stat_bypass_pkts, m_cnt_by);
        check("stat_orphan", stat_orphan_beats, m_orphan);

        // Advance the model by the handshakes that complete on the next edge.
        if (out_meta_valid && out_meta_ready && meta_q_nf.size() != 0) void'(meta_q_nf.pop_front());
        if (bypass_meta_valid && bypass_meta_ready && meta_q_by.size() != 0) void'(meta_q_by.pop_front());
        if (in_pkt_valid && in_pkt_ready) begin
          if (m_active) begin
            if (in_pkt_eop) begin
              m_active = 1'b0;
              if (m_dest) m_cnt_by++;
              else        m_cnt_nf++;
            end
          end else begin
            m_orphan++;
          end
        end
        if (in_meta_valid && in_meta_ready) begin
          m_md     = in_meta_data;
          m_dest   = m_md.bypass | (FORCE_DUT & (out_pkt_almost_full | out_meta_almost_full));
          m_active = 1'b1;
          if (m_dest) meta_q_by.push_back(in_meta_data);
          else        meta_q_nf.push_back(in_meta_data);
        end
      end
      if (out_pkt_valid && out_pkt_ready) nf_beats++;
      if (bypass_pkt_valid && bypass_pkt_ready) begin
        byp_beats++;
        last_byp_empty = bypass_pkt_empty;
      end
      if (bypass_pkt_valid || bypass_meta_valid) byp_valid_cycles++;
      if (!nf_rst) begin
        check("nf2_no_bypass", nf2_bypass_pkt_valid | nf2_bypass_meta_valid, 1'b0);
        if (nf2_out_pkt_valid) nf2_beats++;
      end
    end
  end

  // Sink readiness / almost-full: 0 = always ready, 1 = random, 2 = driven by the test.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0) begin
      out_pkt_ready = 1'b1;  out_meta_ready = 1'b1;
      bypass_pkt_ready = 1'b1; bypass_meta_ready = 1'b1;
      out_pkt_almost_full = 1'b0; out_meta_almost_full = 1'b0;
    end else if (rdy_mode == 1) begin
      out_pkt_ready     = ($urandom_range(3) != 0);
      out_meta_ready    = ($urandom_range(3) != 0);
      bypass_pkt_ready  = ($urandom_range(3) != 0);
      bypass_meta_ready = ($urandom_range(3) != 0);
      out_pkt_almost_full  = ($urandom_range(7) == 0);
      out_meta_almost_full = ($urandom_range(7) == 0);
    end
  end

  task automatic wait_meta_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk);
      ok = in_meta_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_pkt_hs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk);
      ok = in_pkt_ready;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [PKT_W-1:0] rand_beat();
    logic [PKT_W-1:0] d;
    for (int w = 0; w < PKT_W / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [META_W-1:0] rand_meta(input bit byp);
    metadata_t md;
    md = $urandom();
    md.bypass = byp;
    return md;
  endfunction

  // Sends one packet; rst_at / af_clear_at name the beat index on which reset
  // is pulsed or almost-full is dropped (-1 = never).
  task automatic send_pkt(input logic [META_W-1:0] meta, input int nbeats,
                          input logic [EMPTY_W-1:0] last_empty, input int gap_max,
                          input int meta_delay, input int rst_at, input int af_clear_at);
    fork
      begin : meta_side
        bit ok;
        repeat (meta_delay) begin @(posedge clk); #1; end
        in_meta_data  = meta;
        in_meta_valid = 1'b1;
        wait_meta_hs(ok);
        in_meta_valid = 1'b0;
        check("meta_handshake", ok, 1'b1);
      end
      begin : pkt_side
        bit ok;
        for (int b = 0; b < nbeats; b++) begin
          repeat ($urandom_range(gap_max)) begin @(posedge clk); #1; end
          in_pkt_data  = rand_beat();
          in_pkt_sop   = (b == 0);
          in_pkt_eop   = (b == nbeats - 1);
          in_pkt_empty = (b == nbeats - 1) ? last_empty : '0;
          in_pkt_valid = 1'b1;
          if (b == rst_at) rst = 1'b1;
          if (b == af_clear_at) begin
            out_pkt_almost_full  = 1'b0;
            out_meta_almost_full = 1'b0;
          end
          wait_pkt_hs(ok);
          rst = 1'b0;
          in_pkt_valid = 1'b0;
          check("beat_handshake", ok, 1'b1);
          if (!ok) break;
        end
      end
    join
  endtask

  task automatic send_orphans(input int n);
    bit ok;
    for (int b = 0; b < n; b++) begin
      in_pkt_data  = rand_beat();
      in_pkt_sop   = 1'b0;
      in_pkt_eop   = (b == n - 1);
      in_pkt_empty = '0;
      in_pkt_valid = 1'b1;
      wait_pkt_hs(ok);
      in_pkt_valid = 1'b0;
      check("orphan_handshake", ok, 1'b1);
    end
  endtask

  task automatic clear_seen();
    nf_beats = 0; byp_beats = 0; byp_valid_cycles = 0; nf2_beats = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [3:0] bp_pat = 4'b1001;

  initial begin
    rst = 1'b1; nf_hold = 1'b1;
    in_pkt_data = '0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0; in_pkt_empty = '0; in_pkt_valid = 1'b0;
    in_meta_data = '0; in_meta_valid = 1'b0;
    out_pkt_ready = 1'b1; out_meta_ready = 1'b1; bypass_pkt_ready = 1'b1; bypass_meta_ready = 1'b1;
    out_pkt_almost_full = 1'b0; out_meta_almost_full = 1'b0;
    m_cnt_nf = '0; m_cnt_by = '0; m_orphan = '0;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_counters", {stat_nf_pkts, stat_bypass_pkts, stat_orphan_beats}, 96'd0);
    check("reset_idle_meta_ready", in_meta_ready, 1'b1);
    @(posedge clk); #1;

    // NF steer, 3 beats.
    clear_seen();
    send_pkt(rand_meta(1'b0), 3, 6'd0, 0, 0, -1, -1);
    idle_cycles(2);
    check("t1_nf_beats", nf_beats, 3);
    check("t1_no_bypass_valid", byp_valid_cycles, 0);
    check("t1_stat_nf", stat_nf_pkts, 32'd1);

    // Bypass steer, single beat with empty=10.
    clear_seen();
    send_pkt(rand_meta(1'b1), 1, 6'd10, 0, 0, -1, -1);
    idle_cycles(2);
    check("t2_byp_beats", byp_beats, 1);
    check("t2_byp_empty", last_byp_empty, 6'd10);
    check("t2_nf_beats", nf_beats, 0);
    check("t2_stat_bypass", stat_bypass_pkts, 32'd1);

    // Forced bypass on almost-full, dropped mid-packet; the unforced instance keeps NF.
    rdy_mode = 2;
    nf_hold = 1'b0;
    out_pkt_almost_full = 1'b1;
    idle_cycles(1);
    clear_seen();
    send_pkt(rand_meta(1'b0), 4, 6'd3, 0, 0, -1, 1);
    idle_cycles(2);
    check("t3_byp_beats", byp_beats, 4);
    check("t3_nf_beats", nf_beats, 0);
    check("t3_noforce_nf_beats", nf2_beats, 4);
    check("t3_noforce_stat_nf", nf2_stat_nf, 32'd1);
    check("t3_stat_bypass", stat_bypass_pkts, 32'd2);
    nf_hold = 1'b1;

    // Back-pressure on both bypass streams.
    clear_seen();
    fork
      begin
        send_pkt(rand_meta(1'b1), 4, 6'd0, 0, 0, -1, -1);
        @(negedge clk);
        check("t4_wait_meta_blocks", in_meta_ready, 1'b0);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          bypass_pkt_ready  = bp_pat[i % 4];
          bypass_meta_ready = (i >= 10);
          @(posedge clk); #1;
        end
        bypass_pkt_ready = 1'b1;
        bypass_meta_ready = 1'b1;
      end
    join
    idle_cycles(2);
    check("t4_byp_beats", byp_beats, 4);
    check("t4_stat_bypass", stat_bypass_pkts, 32'd3);
    rdy_mode = 0;

    // Reset on beat 2 of 5; beats 3..5 become orphans.
    send_pkt(rand_meta(1'b0), 5, 6'd0, 0, 0, 1, -1);
    idle_cycles(1);
    @(negedge clk);
    check("t5_orphans", stat_orphan_beats, 32'd3);
    check("t5_nf_after_reset", stat_nf_pkts, 32'd0);
    check("t5_byp_after_reset", stat_bypass_pkts, 32'd0);
    @(posedge clk); #1;
    send_pkt(rand_meta(1'b0), 2, 6'd5, 0, 0, -1, -1);
    idle_cycles(2);
    check("t5_next_pkt_nf", stat_nf_pkts, 32'd1);

    // Random traffic against the model.
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(4) == 0) send_orphans($urandom_range(1, 3));
      send_pkt(rand_meta($urandom_range(1)), $urandom_range(1, 6), 6'($urandom_range(63)),
               2, $urandom_range(2), -1, -1);
    end
    rdy_mode = 0;
    idle_cycles(4);
    @(negedge clk);
    check("rand_drained_idle", in_meta_ready, 1'b1);
    @(posedge clk); #1;

    // Counter wrap.
    force dut.nf_cnt = 32'hFFFF_FFFF;
    m_cnt_nf = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.nf_cnt;
    @(negedge clk);
    check("wrap_preload", stat_nf_pkts, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    send_pkt(rand_meta(1'b0), 2, 6'd0, 0, 0, -1, -1);
    idle_cycles(1);
    @(negedge clk);
    check("wrap_to_zero", stat_nf_pkts, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bypass_front_split.md
Name: bypass_front_split

Overview:
- Ingress-side counterpart of the bypass merge. Takes one packet stream plus one metadata stream and steers each packet (its metadata and all its beats) either to the NF path (out_*) or to the bypass path (bypass_*).
- The decision is a metadata bypass bit, optionally forced by NF-path back-pressure.
- Sits between the parser/flow stage and the NF/bypass FIFOs, ahead of the back-end merge.

Parameters:
- META_W, $bits(metadata_t), metadata width.
- BYPASS_BIT, 0, bit index in metadata that requests bypass.
- FORCE_ON_AF, 1, when 1 a packet is also bypassed if out_pkt_almost_full or out_meta_almost_full is high at decision time.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_pkt_data/sop/eop/empty/valid  in  512/1/1/6/1  ingress packet stream
- in_pkt_ready  out  1  ingress packet accept
- in_meta_data/valid  in  META_W/1  ingress metadata, one per packet
- in_meta_ready  out  1  metadata accept
- out_pkt_data/sop/eop/empty/valid  out  512/1/1/6/1  NF packet stream
- out_pkt_ready/almost_full  in  1/1  NF packet flow control
- out_meta_data/valid  out  META_W/1  NF metadata
- out_meta_ready/almost_full  in  1/1  NF metadata flow control
- bypass_pkt_data/sop/eop/empty/valid  out  512/1/1/6/1  bypass packet stream
- bypass_pkt_ready  in  1  bypass packet flow control
- bypass_meta_data/valid  out  META_W/1  bypass metadata
- bypass_meta_ready  in  1  bypass metadata flow control
- stat_nf_pkts, stat_bypass_pkts, stat_orphan_beats  out  32 each  counters

Behaviour:
- Clock and reset: one clock clk; rst is synchronous, active-high.
- Reset values: state=IDLE, meta_pend=0, sel=0. All *_valid outputs 0; in_meta_ready 0 in reset cycle. Counters 0.
- FSM states: IDLE, PKT, WAIT_META.
- IDLE:
  - in_meta_ready=1. On in_meta_valid, capture into meta_reg.
  - Latch sel = meta[BYPASS_BIT] | (FORCE_ON_AF & (out_pkt_almost_full | out_meta_almost_full)).
  - Set meta_pend=1 and go to PKT.
  - If in_pkt_valid & !in_pkt_sop in IDLE: drive in_pkt_ready=1, drop the beat, increment stat_orphan_beats.
  - A sop beat in IDLE is held (in_pkt_ready=0).
- Metadata output:
  - meta_reg drives both *_meta_data. Only the selected *_meta_valid = meta_pend.
  - Clear meta_pend on the selected valid & ready.
  - Metadata appears at output cycle t+1 after capture at t. It is independent of beat flow.
- PKT:
  - Pass-through is combinational, zero latency.
  - in_pkt_ready = selected *_pkt_ready.
  - Data/sop/eop/empty fan out to both outputs; only the selected *_pkt_valid = in_pkt_valid.
  - The unselected valid is 0 at all times.
  - On eop accepted: increment stat_nf_pkts (sel=0) or stat_bypass_pkts (sel=1). Next state IDLE if meta_pend is clear (or clears this cycle), else WAIT_META.
  - Single-beat packet (sop&eop) is handled identically.
- WAIT_META: in_pkt_ready=0 and in_meta_ready=0. Go to IDLE when meta_pend clears.
- in_meta_ready is 0 outside IDLE, so at most one packet is in flight. No metadata reordering. Packet order within each output is preserved.
- sel and the force decision are frozen for the whole packet. Almost_full changes mid-packet do not re-steer.
- Counters are 32-bit and wrap at 2^32-1 → 0.
- Reset mid-packet:
  - FSM returns to IDLE, meta_pend cleared, any undelivered metadata is lost.
  - Remaining non-sop beats of that packet are dropped as orphans until the next sop.

Decomposition:
- Shared package (struct_s) holds metadata_t and a BYPASS_BIT localparam matching the metadata layout. Stream widths 512/6 stay as the existing project constants.
- No sub-module is needed. The counter block may be a small generic sat/wrap counter if one already exists in the library; otherwise inline.

Test Plan:
- NF steer: meta bypass bit=0, 3-beat packet, all readies 1.
  - out_meta_valid at t+1, out_pkt_valid on 3 beats, bypass_* valid never 1, stat_nf_pkts=1.
- Bypass steer: meta bit=1, 1-beat packet (sop=eop=1, empty=10).
  - Appears only on bypass_pkt with empty=10, stat_bypass_pkts=1.
- Force on almost-full: bit=0, out_pkt_almost_full=1 at capture, deasserted on beat 2 of 4.
  - All 4 beats on bypass; with FORCE_ON_AF=0 they go to NF.
- Back-pressure: bypass_pkt_ready toggles 1,0,0,1 and bypass_meta_ready held 0 for 10 cycles.
  - No beat lost or duplicated; FSM sits in WAIT_META after eop until meta accepted; next in_meta_ready only afterwards.
- Orphans and reset: assert rst on beat 2 of a 5-beat packet.
  - Outputs/counters 0 next cycle; beats 3–5 dropped, stat_orphan_beats=3; following packet steered normally.
- Counter wrap: preload stat_nf_pkts to 32'hFFFF_FFFF via force, send one NF packet → 0.
